seq_tx_check: RTL and testbench

SEQ_TX_CHECK -- requirements
Module: seq_tx_check

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_model.sv | 27 ++
 rtl/seq_tx_check.sv | 108 ++++++++++
 tb/tb_seq_tx_check.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-detector transmit/check block.
package seq_pkg;

    typedef enum logic [2:0] {
        S0, S1, S2, S3, S4, S5, S6, S7
    } fsm_state_t;

    typedef enum logic [1:0] {
        IDLE, SEND, DONE
    } ctrl_state_t;

    localparam logic [3:0] MAX_LEN = 4'd8;

    // A length of 0 means a full byte; anything above MAX_LEN is clamped.
    function automatic logic [3:0] eff_len(input logic [3:0] len);
        if (len == 4'd0 || len > MAX_LEN)
            return MAX_LEN;
        return len;
    endfunction

endpackage

// File: rtl/seq_model.sv
// Combinational reference model of the Mealy sequence detector under test.
module seq_model
    import seq_pkg::*;
(
    input  fsm_state_t state,
    input  logic       x,
    output fsm_state_t next_state,
    output logic       y_exp
);

    always_comb begin
        next_state = S0;
        y_exp      = 1'b0;
        unique case (state)
            S0: begin next_state = x ? S1 : S5; y_exp = 1'b0;       end
            S1: begin next_state = x ? S2 : S3; y_exp = 1'b0;       end
            S2: begin next_state = x ? S4 : S5; y_exp = 1'b0;       end
            S3: begin next_state = x ? S0 : S6; y_exp = ~x;         end
            S4: begin next_state = x ? S2 : S3; y_exp = 1'b0;       end
            S5: begin next_state = x ? S1 : S5; y_exp = 1'b1;       end
            S6: begin next_state = x ? S7 : S6; y_exp = x;          end
            S7: begin next_state = x ? S0 : S6; y_exp = ~x;         end
            default: begin next_state = S0; y_exp = 1'b0;           end
        endcase
    end

endmodule

// File: rtl/seq_tx_check.sv
// Serialises a burst of bits into the FSM under test and checks its Mealy
// output against a reference model that tracks it bit by bit.
module seq_tx_check
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic [3:0] load_len,
    output logic       x,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] model_state
);

    ctrl_state_t ctrl_q, ctrl_d;
    fsm_state_t  model_q, model_d;
    fsm_state_t  model_next;
    logic        y_exp;
    logic        x_q, x_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mcnt_q, mcnt_d;

    seq_model u_model (
        .state      (model_q),
        .x          (x_q),
        .next_state (model_next),
        .y_exp      (y_exp)
    );

    // x is registered, so the first bit is loaded into x_q on the accept edge
    // and the shift register holds only the bits still to come.
    always_comb begin
        ctrl_d  = ctrl_q;
        model_d = model_q;
        x_d     = x_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        unique case (ctrl_q)
            IDLE: begin
                x_d = 1'b0;
                if (load_valid) begin
                    x_d     = load_data[0];
                    shift_d = load_data >> 1;
                    cnt_d   = eff_len(load_len);
                    mcnt_d  = '0;
                    ctrl_d  = SEND;
                end
            end
            SEND: begin
                model_d = model_next;
                if (y_in != y_exp && mcnt_q < MAX_LEN)
                    mcnt_d = mcnt_q + 4'd1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    ctrl_d  = DONE;
                    x_d     = 1'b0;
                    shift_d = '0;
                end else begin
                    x_d     = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DONE: begin
                x_d    = 1'b0;
                ctrl_d = IDLE;
            end
            default: begin
                x_d    = 1'b0;
                ctrl_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= IDLE;
            model_q <= S0;
            x_q     <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            model_q <= model_d;
            x_q     <= x_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign load_ready   = (ctrl_q == IDLE);
    assign busy         = (ctrl_q == SEND);
    assign done         = (ctrl_q == DONE);
    assign pass         = (ctrl_q == DONE) && (mcnt_q == 4'd0);
    assign x            = x_q;
    assign mismatch_cnt = mcnt_q;
    assign model_state  = model_q;

endmodule

// File: tb/tb_seq_tx_check.sv
// Scoreboard bench for seq_tx_check with a behavioural FSM under test.
module tb_seq_tx_check;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic [3:0] load_len;
    logic       x;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mismatch_cnt;
    logic [2:0] model_state;

    seq_tx_check dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_len     (load_len),
        .x            (x),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .model_state  (model_state)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // returns {next_state, y}
    function automatic logic [3:0] tbl(input logic [2:0] s, input logic b);
        case (s)
            3'd0: return b ? {3'd1, 1'b0} : {3'd5, 1'b0};
            3'd1: return b ? {3'd2, 1'b0} : {3'd3, 1'b0};
            3'd2: return b ? {3'd4, 1'b0} : {3'd5, 1'b0};
            3'd3: return b ? {3'd0, 1'b0} : {3'd6, 1'b1};
            3'd4: return b ? {3'd2, 1'b0} : {3'd3, 1'b0};
            3'd5: return b ? {3'd1, 1'b1} : {3'd5, 1'b1};
            3'd6: return b ? {3'd7, 1'b1} : {3'd6, 1'b0};
            default: return b ? {3'd0, 1'b0} : {3'd6, 1'b1};
        endcase
    endfunction

    // FSM under test: steps only while bits are being sent
    logic [2:0] ref_st;
    logic [3:0] ref_ny;
    logic [1:0] mode;
    always_comb ref_ny = tbl(ref_st, x);
    always @(posedge clk) begin
        if (reset) ref_st <= 3'd0;
        else if (busy) ref_st <= ref_ny[3:1];
    end
    assign y_in = (mode == 2'd0) ? ref_ny[0] : (mode == 2'd2);

    typedef struct { logic xb; logic [2:0] st; } bit_exp_t;
    typedef struct { logic p; logic [3:0] mc; logic [2:0] st; int unsigned len; } done_exp_t;
    bit_exp_t    bit_q[$];
    done_exp_t   done_q[$];
    logic [2:0]  tb_state = 3'd0;
    logic        sb_en = 1'b1;
    int unsigned busy_cycles = 0;
    int unsigned done_seen = 0;

    always @(negedge clk) begin
        if (reset) begin
            busy_cycles = 0;
        end else if (sb_en) begin
            if (busy) begin
                busy_cycles++;
                if (bit_q.size() == 0) begin
                    check("bit_queue_empty", 1, 0);
                end else begin
                    bit_exp_t e;
                    e = bit_q.pop_front();
                    check("x_bit", x, e.xb);
                    check("model_state_send", model_state, e.st);
                end
            end else begin
                check("x_quiet", x, 0);
            end
            if (done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    check("done_queue_empty", 1, 0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    check("pass", pass, d.p);
                    check("mismatch_cnt", mismatch_cnt, d.mc);
                    check("model_state_done", model_state, d.st);
                    check("send_cycles", busy_cycles, d.len);
                end
                busy_cycles = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tb_state = 3'd0;
    endtask

    task automatic burst(input logic [7:0] data, input logic [3:0] len,
                         input logic [1:0] m, input bit interfere);
        int unsigned n;
        int unsigned mis;
        logic [2:0]  st;
        logic [3:0]  r;
        bit          seen;
        n   = (len == 0 || len > 8) ? 8 : len;
        mis = 0;
        st  = tb_state;
        for (int unsigned i = 0; i < n; i++) begin
            bit_q.push_back('{xb: data[i], st: st});
            r = tbl(st, data[i]);
            if (m == 2'd1 && r[0] != 1'b0) mis++;
            if (m == 2'd2 && r[0] != 1'b1) mis++;
            st = r[3:1];
        end
        done_q.push_back('{p: (mis == 0), mc: 4'(mis), st: st, len: n});
        tb_state = st;

        @(negedge clk);
        check("load_ready_idle", load_ready, 1);
        mode       = m;
        load_valid = 1'b1;
        load_data  = data;
        load_len   = len;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                load_valid = 1'b0;
                seen = 1;
                break;
            end
            if (interfere) begin
                check("load_ready_send", load_ready, 0);
                load_valid = 1'b1;
                load_data  = ~data;
                load_len   = 4'd5;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int unsigned d0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        mode       = 2'd0;
        do_reset();
        check("rst_x", x, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_model_state", model_state, 0);
        check("rst_mismatch", mismatch_cnt, 0);

        burst(8'b0000_0011, 4'd3, 2'd1, 0);   // y forced 0, all expected 0
        do_reset();
        burst(8'b0000_0011, 4'd3, 2'd2, 0);   // y forced 1, 3 mismatches
        check("mismatch_hold_idle", mismatch_cnt, 3);
        do_reset();
        burst(8'h00, 4'd3, 2'd0, 0);          // ends in S5, pass
        burst(8'h5A, 4'd0, 2'd0, 0);          // len 0 means 8
        burst(8'hC3, 4'd12, 2'd2, 0);         // clamped to 8
        burst(8'h01, 4'd1, 2'd1, 0);
        burst(8'hB4, 4'd6, 2'd0, 1);          // load_valid during SEND ignored
        for (int i = 0; i < 6; i++)
            burst(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), 0);

        // reset during the second SEND cycle aborts the burst
        sb_en = 1'b0;
        d0 = done_seen;
        @(negedge clk);
        mode       = 2'd0;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        load_len   = 4'd8;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_load_ready", load_ready, 1);
        check("abort_model_state", model_state, 0);
        check("abort_x", x, 0);
        check("abort_done", done, 0);
        tb_state = 3'd0;
        sb_en = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_seen, d0);
        burst(8'h96, 4'd5, 2'd0, 0);

        check("bit_queue_drained", bit_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
